ext_mem_ctrl: RTL and testbench



---
 rtl/ext_mem_ctrl_pkg.sv | 41 ++++
 rtl/ext_mem_ctrl_wait_timer.sv | 47 ++++
 rtl/ext_mem_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_ext_mem_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_ctrl_pkg.sv
// ext_mem_pkg: shared constants, FSM state encoding and small helpers for
// the external-memory responder (ext_mem_ctrl) and its wait timer.
//   SRAM_DQ_BITS  : width of the external SRAM data bus
//   HALF_LO/HI    : halfword select bit appended to the word address
//   WAIT_CNT_BITS : width of the wait-state down-counter
package ext_mem_pkg;

  localparam int   SRAM_DQ_BITS  = 16;
  localparam int   WAIT_CNT_BITS = 4;
  localparam logic HALF_LO       = 1'b0;
  localparam logic HALF_HI       = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_LO   = 3'd1,
    RD_HI   = 3'd2,
    WR_LO   = 3'd3,
    WR_REC0 = 3'd4,
    WR_HI   = 3'd5,
    WR_REC1 = 3'd6,
    DONE    = 3'd7
  } state_e;

  // States in which an SRAM strobe is active and the wait timer runs.
  function automatic logic is_strobe_state(input state_e s);
    case (s)
      RD_LO, RD_HI, WR_LO, WR_HI: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  // Byte-enable pair belonging to one halfword of a 32-bit write.
  function automatic logic [1:0] strb_half(input logic [3:0] s, input logic half);
    if (half) begin
      return s[3:2];
    end else begin
      return s[1:0];
    end
  endfunction

endpackage

// File: rtl/ext_mem_ctrl_wait_timer.sv
// ext_mem_wait_timer: loadable wait-state down-counter.
//   CLK, RSTb  : clock, synchronous active-low reset
//   i_load     : load i_load_val (takes priority over counting)
//   i_load_val : wait-state count to load
//   i_en       : count down while non-zero
//   i_rdy      : (only with EXT_MEM_RDY_EN) external ready qualifier
//   o_done     : count has reached zero (and i_rdy is high, if present)
// Optional macro: EXT_MEM_RDY_EN adds the i_rdy qualifier.
module ext_mem_wait_timer
  import ext_mem_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RSTb,
  input  logic                     i_load,
  input  logic [WAIT_CNT_BITS-1:0] i_load_val,
  input  logic                     i_en,
`ifdef EXT_MEM_RDY_EN
  input  logic                     i_rdy,
`endif
  output logic                     o_done
);

  logic [WAIT_CNT_BITS-1:0] r_cnt;
  logic                     w_zero;

  // Down-counter: saturates at zero so a stalled last cycle simply holds.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_cnt <= {WAIT_CNT_BITS{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != {WAIT_CNT_BITS{1'b0}})) begin
      r_cnt <= r_cnt - WAIT_CNT_BITS'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign w_zero = (r_cnt == {WAIT_CNT_BITS{1'b0}});

`ifdef EXT_MEM_RDY_EN
  assign o_done = w_zero & i_rdy;
`else
  assign o_done = w_zero;
`endif

endmodule

// File: rtl/ext_mem_ctrl.sv
// ext_mem_ctrl: responder for the cache's external memory port. Each 32-bit
// read/write is split into two 16-bit accesses to an asynchronous SRAM with
// programmable wait states. All outputs are registered.
// Ports:
//   CLK, RSTb              : clock, synchronous active-low reset
//   req_addr/wdata/wstrb   : request address (bits [1:0] ignored), data, byte enables
//   req_wr_valid/wr_ready  : write request / one-cycle completion pulse
//   req_rd_ready/rd_valid  : read request / one-cycle data-valid pulse
//   req_rdata              : read data, held until the next read completes
//   sram_addr              : halfword address
//   sram_dq_in/out/oe      : SRAM data bus (input, output, output enable)
//   sram_ceb/oeb/web/lbb/ubb : active-low SRAM strobes
//   sram_rdy               : (only with EXT_MEM_RDY_EN) stretches the last strobe cycle
// Optional macro: EXT_MEM_RDY_EN.
module ext_mem_ctrl
  import ext_mem_pkg::*;
#(
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = 28,
  parameter int WAIT_STATES  = 2
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic [ADDRESS_BITS-1:0] req_addr,
  input  logic [BITS-1:0]         req_wdata,
  input  logic [3:0]              req_wstrb,
  input  logic                    req_wr_valid,
  output logic                    req_wr_ready,
  input  logic                    req_rd_ready,
  output logic                    req_rd_valid,
  output logic [BITS-1:0]         req_rdata,
  output logic [ADDRESS_BITS-2:0] sram_addr,
  input  logic [SRAM_DQ_BITS-1:0] sram_dq_in,
  output logic [SRAM_DQ_BITS-1:0] sram_dq_out,
  output logic                    sram_dq_oe,
  output logic                    sram_ceb,
  output logic                    sram_oeb,
  output logic                    sram_web,
  output logic                    sram_lbb,
`ifdef EXT_MEM_RDY_EN
  output logic                    sram_ubb,
  input  logic                    sram_rdy
`else
  output logic                    sram_ubb
`endif
);

  localparam logic [WAIT_CNT_BITS-1:0] L_WAIT = WAIT_CNT_BITS'(WAIT_STATES);

  state_e                          r_state;
  logic [ADDRESS_BITS-3:0]         r_word;
  logic [BITS-1:0]                 r_wdata;
  logic [3:0]                      r_wstrb;
  logic [SRAM_DQ_BITS-1:0]         r_rd_lo;
  logic                            w_in_strobe;
  logic                            w_done;
  logic                            w_load;
  logic                            w_unused_addr;

  assign w_unused_addr = ^req_addr[1:0];
  assign w_in_strobe   = is_strobe_state(r_state);
  // Outside strobe states the timer is kept preloaded, so it already holds
  // WAIT_STATES on entry; it reloads when a strobe state completes.
  assign w_load        = ~w_in_strobe | w_done;

  ext_mem_wait_timer u_timer (
    .CLK        (CLK),
    .RSTb       (RSTb),
    .i_load     (w_load),
    .i_load_val (L_WAIT),
    .i_en       (w_in_strobe),
`ifdef EXT_MEM_RDY_EN
    .i_rdy      (sram_rdy),
`endif
    .o_done     (w_done)
  );

  // Main FSM; every output is set on the transition into the state it belongs to.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_state      <= IDLE;
      r_word       <= {(ADDRESS_BITS-2){1'b0}};
      r_wdata      <= {BITS{1'b0}};
      r_wstrb      <= 4'h0;
      r_rd_lo      <= {SRAM_DQ_BITS{1'b0}};
      req_wr_ready <= 1'b0;
      req_rd_valid <= 1'b0;
      req_rdata    <= {BITS{1'b0}};
      sram_addr    <= {(ADDRESS_BITS-1){1'b0}};
      sram_dq_out  <= {SRAM_DQ_BITS{1'b0}};
      sram_dq_oe   <= 1'b0;
      sram_ceb     <= 1'b1;
      sram_oeb     <= 1'b1;
      sram_web     <= 1'b1;
      sram_lbb     <= 1'b1;
      sram_ubb     <= 1'b1;
    end else begin
      req_wr_ready <= 1'b0;
      req_rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_wr_valid) begin
            r_word  <= req_addr[ADDRESS_BITS-1:2];
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            if (strb_half(req_wstrb, HALF_LO) != 2'b00) begin
              r_state     <= WR_LO;
              sram_addr   <= {req_addr[ADDRESS_BITS-1:2], HALF_LO};
              sram_dq_out <= req_wdata[15:0];
              sram_dq_oe  <= 1'b1;
              sram_ceb    <= 1'b0;
              sram_web    <= 1'b0;
              sram_lbb    <= ~req_wstrb[0];
              sram_ubb    <= ~req_wstrb[1];
            end else if (strb_half(req_wstrb, HALF_HI) != 2'b00) begin
              r_state     <= WR_HI;
              sram_addr   <= {req_addr[ADDRESS_BITS-1:2], HALF_HI};
              sram_dq_out <= req_wdata[31:16];
              sram_dq_oe  <= 1'b1;
              sram_ceb    <= 1'b0;
              sram_web    <= 1'b0;
              sram_lbb    <= ~req_wstrb[2];
              sram_ubb    <= ~req_wstrb[3];
            end else begin
              // No bytes enabled: acknowledge without touching the SRAM.
              r_state      <= DONE;
              req_wr_ready <= 1'b1;
            end
          end else if (req_rd_ready) begin
            r_word    <= req_addr[ADDRESS_BITS-1:2];
            r_state   <= RD_LO;
            sram_addr <= {req_addr[ADDRESS_BITS-1:2], HALF_LO};
            sram_ceb  <= 1'b0;
            sram_oeb  <= 1'b0;
            sram_lbb  <= 1'b0;
            sram_ubb  <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        RD_LO: begin
          if (w_done) begin
            r_rd_lo   <= sram_dq_in;
            r_state   <= RD_HI;
            sram_addr <= {r_word, HALF_HI};
          end
        end
        RD_HI: begin
          if (w_done) begin
            // Both halves update together so req_rdata never shows a torn word.
            req_rdata    <= {sram_dq_in, r_rd_lo};
            req_rd_valid <= 1'b1;
            r_state      <= DONE;
            sram_ceb     <= 1'b1;
            sram_oeb     <= 1'b1;
            sram_lbb     <= 1'b1;
            sram_ubb     <= 1'b1;
          end
        end
        WR_LO: begin
          if (w_done) begin
            // Recovery: strobes off, address and data kept for hold time.
            r_state  <= WR_REC0;
            sram_ceb <= 1'b1;
            sram_web <= 1'b1;
            sram_lbb <= 1'b1;
            sram_ubb <= 1'b1;
          end
        end
        WR_REC0: begin
          if (strb_half(r_wstrb, HALF_HI) != 2'b00) begin
            r_state     <= WR_HI;
            sram_addr   <= {r_word, HALF_HI};
            sram_dq_out <= r_wdata[31:16];
            sram_dq_oe  <= 1'b1;
            sram_ceb    <= 1'b0;
            sram_web    <= 1'b0;
            sram_lbb    <= ~r_wstrb[2];
            sram_ubb    <= ~r_wstrb[3];
          end else begin
            r_state      <= DONE;
            sram_dq_oe   <= 1'b0;
            req_wr_ready <= 1'b1;
          end
        end
        WR_HI: begin
          if (w_done) begin
            r_state  <= WR_REC1;
            sram_ceb <= 1'b1;
            sram_web <= 1'b1;
            sram_lbb <= 1'b1;
            sram_ubb <= 1'b1;
          end
        end
        WR_REC1: begin
          r_state      <= DONE;
          sram_dq_oe   <= 1'b0;
          req_wr_ready <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          sram_dq_oe <= 1'b0;
          sram_ceb   <= 1'b1;
          sram_oeb   <= 1'b1;
          sram_web   <= 1'b1;
          sram_lbb   <= 1'b1;
          sram_ubb   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_ctrl.sv
// Self-checking bench for ext_mem_ctrl: directed vector table, hand-written
// corner sequences (simultaneous requests, mid-read reset, sram_rdy stall
// when EXT_MEM_RDY_EN is defined) and randomized traffic against a
// byte-level memory model.
module tb_ext_mem_ctrl;

  localparam int W = 2;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic [27:0] req_addr = 28'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic        req_wr_valid = 1'b0;
  logic        req_wr_ready;
  logic        req_rd_ready = 1'b0;
  logic        req_rd_valid;
  logic [31:0] req_rdata;
  logic [26:0] sram_addr;
  logic [15:0] sram_dq_in;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_ceb, sram_oeb, sram_web, sram_lbb, sram_ubb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

`ifdef EXT_MEM_RDY_EN
  logic sram_rdy;
  int   cur_cycle = 0;
  int   rdy_from  = 0;
  int   rdy_to    = -1;
  assign sram_rdy = !((cur_cycle >= rdy_from) && (cur_cycle <= rdy_to));
`endif

  ext_mem_ctrl #(.BITS(32), .ADDRESS_BITS(28), .WAIT_STATES(W)) dut (
    .CLK          (CLK),
    .RSTb         (RSTb),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .req_wr_valid (req_wr_valid),
    .req_wr_ready (req_wr_ready),
    .req_rd_ready (req_rd_ready),
    .req_rd_valid (req_rd_valid),
    .req_rdata    (req_rdata),
    .sram_addr    (sram_addr),
    .sram_dq_in   (sram_dq_in),
    .sram_dq_out  (sram_dq_out),
    .sram_dq_oe   (sram_dq_oe),
    .sram_ceb     (sram_ceb),
    .sram_oeb     (sram_oeb),
    .sram_web     (sram_web),
    .sram_lbb     (sram_lbb),
`ifdef EXT_MEM_RDY_EN
    .sram_ubb     (sram_ubb),
    .sram_rdy     (sram_rdy)
`else
    .sram_ubb     (sram_ubb)
`endif
  );

  // Asynchronous SRAM device: byte-masked write while ceb/web low, combinational read.
  logic [15:0] mem16 [0:4095] = '{default: 16'h0000};
  logic [15:0] w_bus;
  assign w_bus      = sram_dq_oe ? sram_dq_out : 16'hFFFF;
  assign sram_dq_in = (!sram_ceb && !sram_oeb) ? mem16[sram_addr[11:0]] : 16'h0000;

  always @(posedge CLK) begin
    if (!sram_ceb && !sram_web) begin
      if (!sram_lbb) mem16[sram_addr[11:0]][7:0]  <= w_bus[7:0];
      if (!sram_ubb) mem16[sram_addr[11:0]][15:8] <= w_bus[15:8];
    end
  end

  // Reference: word memory updated byte by byte from the request stream.
  logic [31:0] ref_mem [0:2047];

  task automatic model_write(input logic [27:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[12:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic int exp_wr_lat(input logic [3:0] s);
    int l;
    l = 1;
    if (s[1:0] != 2'b00) l += W + 2;
    if (s[3:2] != 2'b00) l += W + 2;
    return l;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One request from an idle port; returns completion cycle and strobe statistics.
  task automatic do_txn(input bit wr, input logic [27:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat, output logic [31:0] rd,
                        output int n_oeb, output int n_web, output int n_ceb,
                        output int n_lb_only, output int n_web_lo);
    @(posedge CLK); #1;
    req_addr = a; req_wdata = d; req_wstrb = s;
    req_wr_valid = wr; req_rd_ready = !wr;
    lat = -1; rd = 32'h0; n_oeb = 0; n_web = 0; n_ceb = 0; n_lb_only = 0; n_web_lo = 0;
`ifdef EXT_MEM_RDY_EN
    cur_cycle = 0;
`endif
    for (int c = 1; c <= 100; c++) begin
      @(posedge CLK); #1;
`ifdef EXT_MEM_RDY_EN
      cur_cycle = c;
`endif
      if (!sram_oeb) n_oeb++;
      if (!sram_web) n_web++;
      if (!sram_ceb) n_ceb++;
      if (!sram_web && !sram_lbb && sram_ubb) n_lb_only++;
      if (!sram_web && !sram_addr[0]) n_web_lo++;
      if ((wr && req_wr_ready) || (!wr && req_rd_valid)) begin
        lat = c;
        rd  = req_rdata;
        break;
      end
    end
    req_wr_valid = 1'b0;
    req_rd_ready = 1'b0;
`ifdef EXT_MEM_RDY_EN
    cur_cycle = 0;
`endif
  endtask

  typedef struct {
    bit          wr;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    logic [31:0] rdata;
    int          oeb;
    int          web;
    int          ceb;
    int          lb_only;
    int          web_lo;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat, n_oeb, n_web, n_ceb, n_lb, n_wlo, wlat, rlat, pulses;
    logic [31:0] rd, last_rd;
    bit          wr;
    logic [27:0] a;
    logic [31:0] d;
    logic [3:0]  s;

    for (int i = 0; i < 2048; i++) ref_mem[i] = 32'h0;

    // wr, addr, wdata, wstrb, lat, rdata, oeb, web, ceb, lb_only, web_lo
    vecs[0] = '{1'b0, 28'h200, 32'h0,        4'h0, 7, 32'hABCD1234, 6, 0, 6, 0, 0};
    vecs[1] = '{1'b1, 28'h400, 32'hDEADBEEF, 4'hF, 9, 32'h0,        0, 6, 6, 0, 3};
    vecs[2] = '{1'b0, 28'h400, 32'h0,        4'h0, 7, 32'hDEADBEEF, 6, 0, 6, 0, 0};
    vecs[3] = '{1'b1, 28'h800, 32'hDEADBEEF, 4'h4, 5, 32'h0,        0, 3, 3, 3, 0};
    vecs[4] = '{1'b0, 28'h802, 32'h0,        4'h0, 7, 32'h11AD3344, 6, 0, 6, 0, 0};
    vecs[5] = '{1'b1, 28'h404, 32'hFFFFFFFF, 4'h0, 1, 32'h0,        0, 0, 0, 0, 0};
    vecs[6] = '{1'b0, 28'h404, 32'h0,        4'h0, 7, 32'h00000000, 6, 0, 6, 0, 0};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_wr_ready", 64'(req_wr_ready), 64'h0);
    chk("rst_rd_valid", 64'(req_rd_valid), 64'h0);
    chk("rst_rdata", 64'(req_rdata), 64'h0);
    chk("rst_sram_addr", 64'(sram_addr), 64'h0);
    chk("rst_dq_out", 64'(sram_dq_out), 64'h0);
    chk("rst_dq_oe", 64'(sram_dq_oe), 64'h0);
    chk("rst_strobes", 64'({sram_ceb, sram_oeb, sram_web, sram_lbb, sram_ubb}), 64'h1F);
    RSTb = 1'b1;

    // Preload memory through the port (hw 0x100=0x1234, 0x101=0xABCD; word 0x800=0x11223344)
    do_txn(1'b1, 28'h200, 32'hABCD1234, 4'hF, lat, rd, n_oeb, n_web, n_ceb, n_lb, n_wlo);
    model_write(28'h200, 32'hABCD1234, 4'hF);
    do_txn(1'b1, 28'h800, 32'h11223344, 4'hF, lat, rd, n_oeb, n_web, n_ceb, n_lb, n_wlo);
    model_write(28'h800, 32'h11223344, 4'hF);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
             lat, rd, n_oeb, n_web, n_ceb, n_lb, n_wlo);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].rdata));
      chk($sformatf("vec%0d_oeb_low", i), 64'(n_oeb), 64'(vecs[i].oeb));
      chk($sformatf("vec%0d_web_low", i), 64'(n_web), 64'(vecs[i].web));
      chk($sformatf("vec%0d_ceb_low", i), 64'(n_ceb), 64'(vecs[i].ceb));
      chk($sformatf("vec%0d_lb_only", i), 64'(n_lb), 64'(vecs[i].lb_only));
      chk($sformatf("vec%0d_web_lo_half", i), 64'(n_wlo), 64'(vecs[i].web_lo));
      if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
    end
    chk("sram_hw200", 64'(mem16[12'h200]), 64'hBEEF);
    chk("sram_hw201", 64'(mem16[12'h201]), 64'hDEAD);
    chk("sram_hw400_untouched", 64'(mem16[12'h400]), 64'h3344);
    chk("sram_hw401_lowbyte", 64'(mem16[12'h401]), 64'h11AD);

    // Simultaneous write+read to 0x400: write first, read returns new data
    do_txn(1'b1, 28'h400, 32'h00000000, 4'hF, lat, rd, n_oeb, n_web, n_ceb, n_lb, n_wlo);
    model_write(28'h400, 32'h00000000, 4'hF);
    @(posedge CLK); #1;
    req_addr = 28'h400; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
    req_wr_valid = 1'b1; req_rd_ready = 1'b1;
    wlat = -1; rlat = -1; rd = 32'h0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge CLK); #1;
      if (req_wr_ready) begin wlat = c; req_wr_valid = 1'b0; end
      if (req_rd_valid) begin rlat = c; rd = req_rdata; req_rd_ready = 1'b0; break; end
    end
    req_wr_valid = 1'b0; req_rd_ready = 1'b0;
    model_write(28'h400, 32'hDEADBEEF, 4'hF);
    chk("simul_wr_latency", 64'(wlat), 64'(2*W+5));
    chk("simul_rd_latency", 64'(rlat), 64'(2*W+5 + 1 + 2*W+3));
    chk("simul_rdata", 64'(rd), 64'hDEADBEEF);
    last_rd = 32'hDEADBEEF;

    // Reset in the 2nd cycle of RD_HI
    @(posedge CLK); #1;
    req_addr = 28'h200; req_rd_ready = 1'b1;
    for (int c = 1; c <= W + 3; c++) begin
      @(posedge CLK); #1;
    end
    chk("midrst_was_reading", 64'({sram_oeb, sram_addr[0]}), 64'h1);
    RSTb = 1'b0;
    @(posedge CLK); #1;
    chk("midrst_strobes", 64'({sram_ceb, sram_oeb, sram_web, sram_lbb, sram_ubb}), 64'h1F);
    chk("midrst_rd_valid", 64'(req_rd_valid), 64'h0);
    RSTb = 1'b1; req_rd_ready = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #1;
      if (req_rd_valid) pulses++;
    end
    chk("midrst_no_pulse", 64'(pulses), 64'h0);
    last_rd = 32'h0;

`ifdef EXT_MEM_RDY_EN
    // sram_rdy low for 4 cycles from the last RD_LO strobe cycle
    rdy_from = W + 1; rdy_to = W + 4;
    do_txn(1'b0, 28'h200, 32'h0, 4'h0, lat, rd, n_oeb, n_web, n_ceb, n_lb, n_wlo);
    rdy_from = 0; rdy_to = -1;
    chk("rdy_stall_latency", 64'(lat), 64'(2*W+3 + 4));
    chk("rdy_stall_rdata", 64'(rd), 64'(ref_mem[11'h080]));
    last_rd = ref_mem[11'h080];
`endif

    // Randomized traffic against the reference memory
    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 28'($urandom_range(0, 4095));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      do_txn(wr, a, d, s, lat, rd, n_oeb, n_web, n_ceb, n_lb, n_wlo);
      if (wr) begin
        model_write(a, d, s);
        chk($sformatf("rnd%0d_wr_latency", i), 64'(lat), 64'(exp_wr_lat(s)));
        chk($sformatf("rnd%0d_web_low", i), 64'(n_web),
            64'((W + 1) * (int'(s[1:0] != 2'b00) + int'(s[3:2] != 2'b00))));
        chk($sformatf("rnd%0d_rdata_hold", i), 64'(req_rdata), 64'(last_rd));
      end else begin
        chk($sformatf("rnd%0d_rd_latency", i), 64'(lat), 64'(2*W+3));
        chk($sformatf("rnd%0d_rdata", i), 64'(rd), 64'(ref_mem[a[12:2]]));
        last_rd = ref_mem[a[12:2]];
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
